// File: rtl/fifo_serializer_if.sv
// Handshake bundle between a fall-through FIFO, the serializer and the serial sink.
// master = serializer side, slave = FIFO/sink environment side.
interface fifo_serializer_if #(
  parameter int WIDTH = 32
);
  logic             enable;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_read;
  logic             sdata;
  logic             sframe;
  logic             busy;
  logic [15:0]      words_sent;

  modport master (
    input  enable, fifo_empty, fifo_data,
    output fifo_read, sdata, sframe, busy, words_sent
  );

  modport slave (
    output enable, fifo_empty, fifo_data,
    input  fifo_read, sdata, sframe, busy, words_sent
  );
endinterface

// File: rtl/fifo_serializer.sv
// Pops words from a fall-through FIFO and shifts them out serially with a framing qualifier.
// Define FIFO_SERIALIZER_PARITY_EN to append an even-parity bit after each word.
module fifo_serializer #(
  parameter int WIDTH     = 32,
  parameter int DIVIDER   = 4,
  parameter int GAP_BITS  = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              reset,
  fifo_serializer_if.master bus
);
`ifdef FIFO_SERIALIZER_PARITY_EN
  localparam int LEN = WIDTH + 1;
`else
  localparam int LEN = WIDTH;
`endif
  localparam int BW = $clog2(WIDTH + 1);
  localparam int DW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(LEN - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIVIDER - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
`ifdef FIFO_SERIALIZER_PARITY_EN
  localparam logic [BW-1:0] DATA_LAST = BW'(WIDTH - 1);
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  localparam state_t AFTER_WORD = (GAP_BITS > 0) ? GAP : IDLE;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [DW-1:0]    div_q, div_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             sdata_q, sdata_d;
  logic             sframe_q, sframe_d;
  logic [15:0]      words_q, words_d;
`ifdef FIFO_SERIALIZER_PARITY_EN
  logic             par_q, par_d;
`endif

  logic fifo_read;
  logic busy;
  logic div_end, bit_end, gap_end, next_bit;

  assign div_end  = (div_q == DIV_LAST);
  assign bit_end  = (bit_q == BIT_LAST);
  assign gap_end  = (gap_q == GAP_LAST);
  // The shift register is pre-shifted at capture, so the next bit always sits at the edge.
  assign next_bit = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bit_q    <= '0;
      div_q    <= '0;
      gap_q    <= '0;
      sdata_q  <= 1'b0;
      sframe_q <= 1'b0;
      words_q  <= '0;
`ifdef FIFO_SERIALIZER_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bit_q    <= bit_d;
      div_q    <= div_d;
      gap_q    <= gap_d;
      sdata_q  <= sdata_d;
      sframe_q <= sframe_d;
      words_q  <= words_d;
`ifdef FIFO_SERIALIZER_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fifo_read) state_d = SHIFT;
      SHIFT:   if (div_end && bit_end) state_d = AFTER_WORD;
      GAP:     if (div_end && gap_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fifo_read = (state_q == IDLE) && bus.enable && !bus.fifo_empty && !reset;
    busy      = (state_q != IDLE);
  end

  always_comb begin
    shreg_d  = shreg_q;
    bit_d    = bit_q;
    div_d    = div_q;
    gap_d    = gap_q;
    sdata_d  = sdata_q;
    sframe_d = sframe_q;
    words_d  = words_q;
`ifdef FIFO_SERIALIZER_PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (fifo_read) begin
          shreg_d  = (MSB_FIRST != 0) ? (bus.fifo_data << 1) : (bus.fifo_data >> 1);
          sdata_d  = (MSB_FIRST != 0) ? bus.fifo_data[WIDTH-1] : bus.fifo_data[0];
          sframe_d = 1'b1;
          bit_d    = '0;
          div_d    = '0;
`ifdef FIFO_SERIALIZER_PARITY_EN
          par_d    = ^bus.fifo_data;
`endif
        end
      end
      SHIFT: begin
        if (div_end) begin
          div_d = '0;
          if (bit_end) begin
            words_d  = words_q + 16'd1;
            sdata_d  = 1'b0;
            sframe_d = 1'b0;
            gap_d    = '0;
          end else begin
            bit_d   = bit_q + BW'(1);
            shreg_d = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);
`ifdef FIFO_SERIALIZER_PARITY_EN
            sdata_d = (bit_q == DATA_LAST) ? par_q : next_bit;
`else
            sdata_d = next_bit;
`endif
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      GAP: begin
        if (div_end) begin
          div_d = '0;
          gap_d = gap_q + GW'(1);
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      default: ;
    endcase
  end

  assign bus.fifo_read  = fifo_read;
  assign bus.busy       = busy;
  assign bus.sdata      = sdata_q;
  assign bus.sframe     = sframe_q;
  assign bus.words_sent = words_q;
endmodule

// File: tb/tb_fifo_serializer.sv
// Randomized bench for fifo_serializer against a timeline model of the serial frame.
module tb_fifo_serializer;
  localparam int W   = 32;
  localparam int D   = 4;
  localparam int G   = 1;
  localparam int MSB = 1;
`ifdef FIFO_SERIALIZER_PARITY_EN
  localparam int LEN = W + 1;
`else
  localparam int LEN = W;
`endif
  localparam int LD = LEN * D;
  localparam int P  = LD + G * D + 1;

  logic clk;
  logic reset;

  fifo_serializer_if #(.WIDTH(W)) bus ();

  fifo_serializer #(.WIDTH(W), .DIVIDER(D), .GAP_BITS(G), .MSB_FIRST(MSB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [W-1:0] fq[$];
  int           rd_cycs[$];
  logic         sbits[$];
  int           cyc = 0;
  int           have = 0;
  int           cap = 0;
  logic [W-1:0] word = '0;
  logic [15:0]  ws_m = '0;
  int           sf_cnt, gap_cnt, sd_hi, busy_cnt;

  function automatic logic exp_bit(logic [W-1:0] w, int idx);
    if (idx >= W) return ^w;
    return (MSB != 0) ? w[W-1-idx] : w[idx];
  endfunction

  function automatic logic [W-1:0] rebuild(int base);
    logic [W-1:0] r = '0;
    for (int k = 0; k < W; k++) begin
      if (MSB != 0) r[W-1-k] = sbits[base + k*D];
      else          r[k]     = sbits[base + k*D];
    end
    return r;
  endfunction

  task automatic clear_obs();
    rd_cycs.delete();
    sbits.delete();
    sf_cnt = 0; gap_cnt = 0; sd_hi = 0; busy_cnt = 0;
  endtask

  // One clock cycle: compare against the model, then advance model and FIFO at the edge.
  task automatic step();
    int   off;
    logic e_busy, e_frame, e_sd, e_rd;
    logic [3:0] e_v, g_v;
    bus.fifo_empty = (fq.size() == 0);
    bus.fifo_data  = (fq.size() != 0) ? fq[0] : '0;
    #1;
    if (have != 0 && cyc == cap + LD + 1) ws_m = ws_m + 16'd1;
    off     = cyc - cap;
    e_frame = (have != 0) && off >= 1 && off <= LD;
    e_busy  = (have != 0) && off >= 1 && off <= LD + G*D;
    e_sd    = e_frame ? exp_bit(word, (off - 1) / D) : 1'b0;
    e_rd    = !e_busy && bus.enable && (fq.size() != 0) && !reset;
    e_v = {e_rd, e_busy, e_frame, e_sd};
    g_v = {bus.fifo_read, bus.busy, bus.sframe, bus.sdata};
    total++;
    if (g_v !== e_v) $display("FAIL cycle %0d {read,busy,sframe,sdata}: got %b expected %b", cyc, g_v, e_v);
    else passed++;
    total++;
    if (bus.words_sent !== ws_m) $display("FAIL cycle %0d words_sent: got %0d expected %0d", cyc, bus.words_sent, ws_m);
    else passed++;
    if (bus.sframe === 1'b1) begin sf_cnt++; sbits.push_back(bus.sdata); end
    if (bus.busy === 1'b1 && bus.sframe === 1'b0) gap_cnt++;
    if (bus.sdata === 1'b1) sd_hi++;
    if (bus.busy === 1'b1) busy_cnt++;
    if (reset) begin have = 0; ws_m = '0; end
    else if (e_rd) begin have = 1; cap = cyc; word = fq[0]; end
    if (bus.fifo_read === 1'b1) begin
      rd_cycs.push_back(cyc);
      if (fq.size() != 0) void'(fq.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic run_to_bit(int b);
    int n = 0;
    while (!(have != 0 && cyc == cap + 1 + b*D) && n < 400) begin step(); n++; end
    total++;
    if (n >= 400) $display("FAIL run_to_bit%0d: timeout after %0d cycles", b, n);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.enable = 1'b1;
    fq.push_back(32'hA5A5_0001);
    bus.fifo_empty = 1'b0;
    bus.fifo_data  = fq[0];
    repeat (3) @(negedge clk);
    #1;
    total++; if (bus.sdata !== 1'b0) $display("FAIL reset_sdata: got %b expected 0", bus.sdata); else passed++;
    total++; if (bus.sframe !== 1'b0) $display("FAIL reset_sframe: got %b expected 0", bus.sframe); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else passed++;
    total++; if (bus.words_sent !== 16'd0) $display("FAIL reset_words: got %0d expected 0", bus.words_sent); else passed++;
    total++; if (bus.fifo_read !== 1'b0) $display("FAIL reset_read: got %b expected 0", bus.fifo_read); else passed++;
    fq.delete();
    bus.enable = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    fq.push_back(32'h0000_0009);
    bus.enable = 1'b1;
    clear_obs();
    repeat (P + 5) step();
    total++; if (rd_cycs.size() != 1) $display("FAIL single_reads: got %0d expected 1", rd_cycs.size()); else passed++;
    total++; if (sf_cnt != LD) $display("FAIL single_sframe_len: got %0d expected %0d", sf_cnt, LD); else passed++;
    total++; if (gap_cnt != G*D) $display("FAIL single_gap_len: got %0d expected %0d", gap_cnt, G*D); else passed++;
    total++; if (rebuild(0) !== 32'h9) $display("FAIL single_word: got %h expected 00000009", rebuild(0)); else passed++;
`ifdef FIFO_SERIALIZER_PARITY_EN
    total++; if (sbits[W*D] !== 1'b0) $display("FAIL single_parity: got %b expected 0", sbits[W*D]); else passed++;
`endif
    total++; if (bus.words_sent !== 16'd1) $display("FAIL single_words: got %0d expected 1", bus.words_sent); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL single_busy_end: got %b expected 0", bus.busy); else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    fq.push_back(32'h1); fq.push_back(32'h2); fq.push_back(32'h3);
    bus.enable = 1'b1;
    clear_obs();
    repeat (3*P + 5) step();
    total++; if (rd_cycs.size() != 3) $display("FAIL b2b_reads: got %0d expected 3", rd_cycs.size()); else passed++;
    if (rd_cycs.size() == 3) begin
      total++; if (rd_cycs[1] - rd_cycs[0] != P) $display("FAIL b2b_period0: got %0d expected %0d", rd_cycs[1] - rd_cycs[0], P); else passed++;
      total++; if (rd_cycs[2] - rd_cycs[1] != P) $display("FAIL b2b_period1: got %0d expected %0d", rd_cycs[2] - rd_cycs[1], P); else passed++;
    end
    total++; if (sbits.size() != 3*LD) $display("FAIL b2b_frame_cycles: got %0d expected %0d", sbits.size(), 3*LD); else passed++;
    total++; if (rebuild(0) !== 32'h1) $display("FAIL b2b_word0: got %h expected 00000001", rebuild(0)); else passed++;
    total++; if (rebuild(LD) !== 32'h2) $display("FAIL b2b_word1: got %h expected 00000002", rebuild(LD)); else passed++;
    total++; if (rebuild(2*LD) !== 32'h3) $display("FAIL b2b_word2: got %h expected 00000003", rebuild(2*LD)); else passed++;
    total++; if (bus.words_sent !== 16'd3) $display("FAIL b2b_words: got %0d expected 3", bus.words_sent); else passed++;
  endtask

  task automatic test_empty();
    do_reset();
    bus.enable = 1'b1;
    clear_obs();
    repeat (200) step();
    total++; if (rd_cycs.size() != 0) $display("FAIL empty_reads: got %0d expected 0", rd_cycs.size()); else passed++;
    total++; if (sf_cnt + sd_hi + busy_cnt != 0) $display("FAIL empty_activity: got sframe=%0d sdata=%0d busy=%0d expected 0", sf_cnt, sd_hi, busy_cnt); else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    fq.push_back(32'hFFFF_FFFF);
    bus.enable = 1'b1;
    clear_obs();
    run_to_bit(10);
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if (bus.sdata !== 1'b0) $display("FAIL rstmid_sdata: got %b expected 0", bus.sdata); else passed++;
    total++; if (bus.sframe !== 1'b0) $display("FAIL rstmid_sframe: got %b expected 0", bus.sframe); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", bus.busy); else passed++;
    total++; if (bus.words_sent !== 16'd0) $display("FAIL rstmid_words: got %0d expected 0", bus.words_sent); else passed++;
    repeat (20) step();
    total++; if (rd_cycs.size() != 1) $display("FAIL rstmid_reads: got %0d expected 1", rd_cycs.size()); else passed++;
  endtask

  task automatic test_enable_drop();
    do_reset();
    fq.push_back($urandom); fq.push_back($urandom);
    bus.enable = 1'b1;
    clear_obs();
    run_to_bit(5);
    bus.enable = 1'b0;
    rd_cycs.delete();
    repeat (P + 20) step();
    total++; if (rd_cycs.size() != 0) $display("FAIL endrop_reads: got %0d expected 0", rd_cycs.size()); else passed++;
    total++; if (fq.size() != 1) $display("FAIL endrop_fifo_left: got %0d expected 1", fq.size()); else passed++;
    total++; if (bus.words_sent !== 16'd1) $display("FAIL endrop_words: got %0d expected 1", bus.words_sent); else passed++;
    bus.enable = 1'b1;
    repeat (P + 2) step();
    total++; if (rd_cycs.size() != 1) $display("FAIL endrop_resume_reads: got %0d expected 1", rd_cycs.size()); else passed++;
    total++; if (fq.size() != 0) $display("FAIL endrop_resume_fifo: got %0d expected 0", fq.size()); else passed++;
  endtask

  task automatic test_random();
    do_reset();
    bus.enable = 1'b1;
    clear_obs();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 63) == 0 && fq.size() < 4) fq.push_back($urandom);
      if ($urandom_range(0, 49) == 0) bus.enable = ~bus.enable;
      reset = ($urandom_range(0, 999) == 0);
      step();
    end
    reset = 1'b0;
    total++; if (rd_cycs.size() == 0) $display("FAIL random_no_traffic: got 0 reads expected >0"); else passed++;
  endtask

  initial begin
    reset = 1'b1;
    bus.enable = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.fifo_data = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_empty();
    test_reset_mid();
    test_enable_drop();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fifo_serializer.md
# fifo_serializer

Downstream drain stage for the team's `fifo` block, configured with `FIRSTWORD_FALLTHROUGH=1`. Pops words from the FIFO and shifts each word out on a single serial line, with a programmable bit period and an inter-word gap. Frames each word with a `sframe` qualifier. Sits between the FIFO's consumer side and an off-block serial sink.

## Interface
Parameters:
- `WIDTH`, 32: data word width; matches FIFO `datain`/`dataout` width.
- `DIVIDER`, 4: `clk` cycles per serial bit; legal range ≥1.
- `GAP_BITS`, 1: idle bit periods inserted after each word; legal range ≥0.
- `MSB_FIRST`, 1: 1 shifts bit `WIDTH-1` first; 0 shifts bit 0 first.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  permits fetching new words.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_data`  in  WIDTH  FIFO head word; valid whenever `fifo_empty`=0 (fall-through).
- `fifo_read`  out  1  pop strobe; FIFO pops at the same edge the word is captured.
- `sdata`  out  1  serial data, registered.
- `sframe`  out  1  high while word bits (and parity, if built) are driven, registered.
- `busy`  out  1  high in any state other than IDLE.
- `words_sent`  out  16  count of completed words; wraps 0xFFFF→0x0000.

## Operation
- States: IDLE, SHIFT, GAP.
- IDLE:
  - `fifo_read` = `enable` & ~`fifo_empty`. Combinational from the registered state, high only in IDLE.
  - When `fifo_read` is high: shift register ← `fifo_data`, bit counter ← 0, divider counter ← 0, next state SHIFT.
- SHIFT:
  - `sframe`=1.
  - `sdata` = current bit, held for `DIVIDER` cycles.
  - After the last bit's final cycle: `words_sent`+1, then GAP if `GAP_BITS`>0, otherwise IDLE.
- GAP:
  - `sdata`=0, `sframe`=0 for `GAP_BITS`×`DIVIDER` cycles, then IDLE.
- `enable` is sampled only in IDLE. Deasserting it mid-word lets the current word and its gap complete; no further pop follows.
- `fifo_empty` rising while in SHIFT or GAP has no effect on the word in flight.
- `fifo_read` never asserts while `fifo_empty`=1 or while `reset`=1.
- Counters:
  - Bit counter width is clog2(`WIDTH`+1).
  - Divider counter width is clog2(`DIVIDER`), minimum 1 bit.
  - `words_sent` is 16-bit unsigned with modulo wrap.

## Timing
- Reset values: `sdata`=0, `sframe`=0, `busy`=0, `words_sent`=0, `fifo_read`=0, state IDLE.
- Reset mid-word abandons the word; outputs take their reset values at the next edge. The popped word is lost and is not re-read.
- Latency:
  - Capture edge at cycle N.
  - First bit on `sdata` and `sframe`=1 in cycles N+1 … N+`DIVIDER`.
- Word length L = `WIDTH` (+1 with parity).
- Back-to-back words, FIFO never empty: `fifo_read` pulses every L×`DIVIDER` + `GAP_BITS`×`DIVIDER` + 1 cycles. The +1 is the IDLE fetch cycle.
- `fifo_read` is high for exactly one cycle per word.
- `busy` rises the cycle after capture and falls on entry to IDLE.

## Configuration
- `FIFO_SERIALIZER_PARITY_EN` defined:
  - Appends one even-parity bit (XOR of all `WIDTH` data bits) after the last data bit.
  - The parity bit lasts `DIVIDER` cycles with `sframe`=1.
  - L = `WIDTH`+1.
- Macro undefined: no parity logic is built; L = `WIDTH`.

## Test plan
- Defaults, FIFO holds 0x00000009, `enable`=1:
  - one-cycle `fifo_read`;
  - `sdata` shows 28 zeros then 1,0,0,1, each bit 4 cycles;
  - `sframe` high for 128 cycles;
  - `words_sent`=1;
  - 4 gap cycles, then `busy`=0.
- Three words preloaded (0x1, 0x2, 0x3): `fifo_read` pulses 133 cycles apart; `words_sent`=3; bit streams in order.
- `fifo_empty`=1 with `enable`=1 for 200 cycles: `fifo_read`, `sdata`, `sframe` and `busy` stay 0.
- `reset` asserted during bit 10 of word 0xFFFFFFFF: next cycle `sdata`=0, `sframe`=0, `busy`=0, `words_sent`=0; no extra `fifo_read`.
- `enable` dropped during bit 5 with 2 words queued: first word completes with its gap; FIFO keeps 1 word; no further `fifo_read` until `enable`=1.
- `FIFO_SERIALIZER_PARITY_EN` build, word 0x00000007:
  - parity bit 1 follows data;
  - `sframe` high for 132 cycles;
  - back-to-back period 137 cycles.
